// File: rtl/btb_update_gen_pkg.sv
// rtl/btb_update_gen_pkg.sv - shared types and helpers for the commit-side BTB update generator
package btb_update_gen_pkg;

  localparam int BTB_UPD_FIFO_DEPTH   = 8;
  localparam int BTB_UPD_COMMIT_WIDTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        jal;
    logic        branch;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } commit_cf_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pred_branch_address;
    logic        jal_inst;
    logic        branch_inst;
    logic        branch_resol;
    logic        ready;
    logic        valid;
  } rob_to_btb_bus;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        jal;
    logic        branch;
    logic        resol;
  } btb_upd_entry_t;

  function automatic logic cf_taken(commit_cf_t c);
    return c.taken | c.jal;
  endfunction

  function automatic logic cf_mispredict(commit_cf_t c);
    return (c.pred_taken != cf_taken(c)) || (cf_taken(c) && (c.pred_target != c.target));
  endfunction

  function automatic logic [31:0] cf_next_pc(commit_cf_t c);
    return cf_taken(c) ? c.target : (c.pc + 32'd4);
  endfunction

  function automatic btb_upd_entry_t cf_to_entry(commit_cf_t c);
    btb_upd_entry_t e;
    e.pc     = c.pc;
    e.target = c.target;
    e.jal    = c.jal;
    e.branch = c.branch;
    e.resol  = cf_taken(c);
    return e;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// rtl/btb_upd_fifo.sv - multi-push, single-pop circular buffer of BTB updates
module btb_upd_fifo
  import btb_update_gen_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BITS  = 3,
  parameter int CW    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BITS:0]                 i_push_cnt,
  input  btb_upd_entry_t [CW-1:0]       i_push_data,
  input  logic                          i_pop,
  output logic [BITS:0]                 o_count,
  output logic [BITS:0]                 o_free_slots,
  output btb_upd_entry_t                o_head
);

  logic [BITS:0]  r_wr_ptr;
  logic [BITS:0]  r_rd_ptr;
  btb_upd_entry_t r_mem [DEPTH];
  logic           w_empty;

  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign o_count      = r_wr_ptr - r_rd_ptr;
  assign o_free_slots = (BITS+1)'(DEPTH) - o_count;
  // An empty buffer forwards the oldest incoming push so it can leave in the same cycle.
  assign o_head       = w_empty ? i_push_data[0] : r_mem[r_rd_ptr[BITS-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + i_push_cnt;
      r_rd_ptr <= r_rd_ptr + (BITS+1)'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < CW; k++) begin
      if ((BITS+1)'(k) < i_push_cnt) begin
        r_mem[r_wr_ptr[BITS-1:0] + BITS'(k)] <= i_push_data[k];
      end
    end
  end

endmodule

// File: rtl/btb_update_gen.sv
// rtl/btb_update_gen.sv - commit-side BTB update stream and mispredict redirect
// Optional statistics outputs enabled by BTB_UPD_STATS_EN.
module btb_update_gen
  import btb_update_gen_pkg::*;
#(
  parameter int COMMIT_WIDTH = BTB_UPD_COMMIT_WIDTH,
  parameter int FIFO_DEPTH   = BTB_UPD_FIFO_DEPTH,
  parameter int FIFO_BITS    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COMMIT_WIDTH-1:0]      commit_valid,
  input  commit_cf_t [COMMIT_WIDTH-1:0] commit_cf,
  output logic                         commit_stall,
  output rob_to_btb_bus                btb_upd,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [31:0]                  stat_cf_commits,
  output logic [31:0]                  stat_mispredicts,
  output logic [31:0]                  stat_stall_cycles
`endif
);

  localparam int LANE_W = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;

  logic                              r_stall;
  rob_to_btb_bus                     r_upd;
  logic                              r_redir_valid;
  logic [31:0]                       r_redir_pc;

  logic [FIFO_BITS:0]                w_push_cnt;
  btb_upd_entry_t [COMMIT_WIDTH-1:0] w_push_data;
  logic [LANE_W-1:0]                 w_slot;
  logic                              w_squash;
  logic                              w_redir_hit;
  logic [31:0]                       w_redir_pc;
  logic                              w_pop;
  logic [FIFO_BITS:0]                w_count;
  logic [FIFO_BITS:0]                w_free_slots;
  logic [FIFO_BITS+1:0]              w_free_after;
  btb_upd_entry_t                    w_head;

  // Lanes scan oldest first; the first mispredict enqueues itself and squashes all younger lanes.
  always_comb begin
    w_push_cnt  = '0;
    w_push_data = '0;
    w_slot      = '0;
    w_squash    = 1'b0;
    w_redir_hit = 1'b0;
    w_redir_pc  = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (commit_valid[i] && !r_stall && !w_squash &&
          (commit_cf[i].jal || commit_cf[i].branch)) begin
        w_slot              = w_push_cnt[LANE_W-1:0];
        w_push_data[w_slot] = cf_to_entry(commit_cf[i]);
        w_push_cnt          = w_push_cnt + (FIFO_BITS+1)'(1);
        if (cf_mispredict(commit_cf[i])) begin
          w_squash    = 1'b1;
          w_redir_hit = 1'b1;
          w_redir_pc  = cf_next_pc(commit_cf[i]);
        end
      end
    end
  end

  assign w_pop        = (w_count != '0) || (w_push_cnt != '0);
  assign w_free_after = {1'b0, w_free_slots} - {1'b0, w_push_cnt} + (FIFO_BITS+2)'(w_pop);

  btb_upd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .BITS  (FIFO_BITS),
    .CW    (COMMIT_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push_cnt   (w_push_cnt),
    .i_push_data  (w_push_data),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_free_slots (w_free_slots),
    .o_head       (w_head)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall       <= 1'b0;
      r_upd         <= '0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      r_stall       <= (w_free_after < (FIFO_BITS+2)'(COMMIT_WIDTH));
      r_redir_valid <= w_redir_hit;
      if (w_redir_hit) begin
        r_redir_pc <= w_redir_pc;
      end
      if (w_pop) begin
        r_upd.pc                  <= w_head.pc;
        r_upd.pred_branch_address <= w_head.target;
        r_upd.jal_inst            <= w_head.jal;
        r_upd.branch_inst         <= w_head.branch;
        r_upd.branch_resol        <= w_head.resol;
        r_upd.ready               <= 1'b1;
        r_upd.valid               <= 1'b1;
      end else begin
        r_upd.ready <= 1'b0;
        r_upd.valid <= 1'b0;
      end
    end
  end

  assign commit_stall   = r_stall;
  assign btb_upd        = r_upd;
  assign redirect_valid = r_redir_valid;
  assign redirect_pc    = r_redir_pc;

`ifdef BTB_UPD_STATS_EN
  logic [31:0] r_stat_cf;
  logic [31:0] r_stat_mis;
  logic [31:0] r_stat_stall;
  logic [32:0] w_cf_sum;

  assign w_cf_sum = {1'b0, r_stat_cf} + 33'(w_push_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_cf    <= '0;
      r_stat_mis   <= '0;
      r_stat_stall <= '0;
    end else begin
      r_stat_cf <= w_cf_sum[32] ? 32'hFFFF_FFFF : w_cf_sum[31:0];
      if (w_redir_hit && (r_stat_mis != 32'hFFFF_FFFF)) begin
        r_stat_mis <= r_stat_mis + 32'd1;
      end
      if (r_stall && (r_stat_stall != 32'hFFFF_FFFF)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign stat_cf_commits   = r_stat_cf;
  assign stat_mispredicts  = r_stat_mis;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_btb_update_gen.sv
// tb/tb_btb_update_gen.sv - directed self-checking bench for btb_update_gen
module tb_btb_update_gen;
  import btb_update_gen_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       commit_valid;
  commit_cf_t [1:0] commit_cf;
  logic             commit_stall;
  rob_to_btb_bus    btb_upd;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
`ifdef BTB_UPD_STATS_EN
  logic [31:0]      stat_cf_commits;
  logic [31:0]      stat_mispredicts;
  logic [31:0]      stat_stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btb_update_gen #(.COMMIT_WIDTH(2), .FIFO_DEPTH(8), .FIFO_BITS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_cf      (commit_cf),
    .commit_stall   (commit_stall),
    .btb_upd        (btb_upd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef BTB_UPD_STATS_EN
    ,
    .stat_cf_commits   (stat_cf_commits),
    .stat_mispredicts  (stat_mispredicts),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    commit_valid = '0;
    commit_cf    = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] pc, input logic jal, input logic br,
                          input logic tk, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
    commit_valid[l]          = 1'b1;
    commit_cf[l].pc          = pc;
    commit_cf[l].jal         = jal;
    commit_cf[l].branch      = br;
    commit_cf[l].taken       = tk;
    commit_cf[l].target      = tgt;
    commit_cf[l].pred_taken  = ptk;
    commit_cf[l].pred_target = ptgt;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    cyc();
    cyc();
    checks++; if (btb_upd !== '0) begin failures++; $display("FAIL reset_btb_upd got=%h exp=0", btb_upd); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_valid got=%b exp=0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin failures++; $display("FAIL reset_redirect_pc got=%h exp=0", redirect_pc); end
    checks++; if (commit_stall !== 1'b0) begin failures++; $display("FAIL reset_commit_stall got=%b exp=0", commit_stall); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_jal();
    clear_inputs();
    set_lane(0, 32'h6000_0010, 1'b1, 1'b0, 1'b1, 32'h6000_0100, 1'b1, 32'h6000_0100);
    cyc();
    clear_inputs();
    checks++; if (btb_upd.valid !== 1'b1 || btb_upd.ready !== 1'b1) begin failures++; $display("FAIL jal_valid got=%b/%b exp=1/1", btb_upd.valid, btb_upd.ready); end
    checks++; if (btb_upd.jal_inst !== 1'b1 || btb_upd.branch_resol !== 1'b1) begin failures++; $display("FAIL jal_flags got=%b/%b exp=1/1", btb_upd.jal_inst, btb_upd.branch_resol); end
    checks++; if (btb_upd.pred_branch_address !== 32'h6000_0100) begin failures++; $display("FAIL jal_target got=%h exp=60000100", btb_upd.pred_branch_address); end
    checks++; if (btb_upd.pc !== 32'h6000_0010) begin failures++; $display("FAIL jal_pc got=%h exp=60000010", btb_upd.pc); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL jal_no_redirect got=%b exp=0", redirect_valid); end
    cyc();
    checks++; if (btb_upd.valid !== 1'b0 || btb_upd.pc !== 32'h6000_0010) begin failures++; $display("FAIL jal_idle_hold got=%b/%h exp=0/60000010", btb_upd.valid, btb_upd.pc); end
  endtask

  task automatic test_dual_branch();
    clear_inputs();
    set_lane(0, 32'h20, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h100);
    set_lane(1, 32'h24, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
    cyc();
    clear_inputs();
    checks++; if (btb_upd.valid !== 1'b1 || btb_upd.pc !== 32'h20 || btb_upd.branch_resol !== 1'b1) begin failures++; $display("FAIL dual_first got=%b/%h/%b exp=1/20/1", btb_upd.valid, btb_upd.pc, btb_upd.branch_resol); end
    cyc();
    checks++; if (btb_upd.valid !== 1'b1 || btb_upd.pc !== 32'h24 || btb_upd.branch_resol !== 1'b0 || btb_upd.pred_branch_address !== 32'h200) begin failures++; $display("FAIL dual_second got=%b/%h/%b/%h exp=1/24/0/200", btb_upd.valid, btb_upd.pc, btb_upd.branch_resol, btb_upd.pred_branch_address); end
    checks++; if (btb_upd.branch_inst !== 1'b1 || btb_upd.jal_inst !== 1'b0) begin failures++; $display("FAIL dual_kind got=%b/%b exp=1/0", btb_upd.branch_inst, btb_upd.jal_inst); end
    cyc();
    checks++; if (btb_upd.valid !== 1'b0) begin failures++; $display("FAIL dual_drained got=%b exp=0", btb_upd.valid); end
  endtask

  task automatic test_mispredict_squash();
    clear_inputs();
    set_lane(0, 32'h40, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
    set_lane(1, 32'h44, 1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h300);
    cyc();
    clear_inputs();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin failures++; $display("FAIL squash_redirect got=%b/%h exp=1/80", redirect_valid, redirect_pc); end
    checks++; if (btb_upd.valid !== 1'b1 || btb_upd.pc !== 32'h40) begin failures++; $display("FAIL squash_enq got=%b/%h exp=1/40", btb_upd.valid, btb_upd.pc); end
    cyc();
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL squash_pulse got=%b exp=0", redirect_valid); end
    checks++; if (btb_upd.valid !== 1'b0) begin failures++; $display("FAIL squash_lane1 got=%b/%h exp=0", btb_upd.valid, btb_upd.pc); end
  endtask

  task automatic test_redirect_cases();
    clear_inputs();
    set_lane(0, 32'h50, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h90);
    cyc();
    clear_inputs();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin failures++; $display("FAIL target_mismatch got=%b/%h exp=1/80", redirect_valid, redirect_pc); end
    cyc();
    checks++; if (redirect_valid !== 1'b0 || btb_upd.valid !== 1'b0) begin failures++; $display("FAIL target_mismatch_idle got=%b/%b exp=0/0", redirect_valid, btb_upd.valid); end
    set_lane(0, 32'h60, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_lane(1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10);
    cyc();
    clear_inputs();
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin failures++; $display("FAIL wrap_redirect got=%b/%h exp=1/0", redirect_valid, redirect_pc); end
    checks++; if (btb_upd.valid !== 1'b1 || btb_upd.pc !== 32'hFFFF_FFFC || btb_upd.branch_resol !== 1'b0) begin failures++; $display("FAIL wrap_enq got=%b/%h/%b exp=1/fffffffc/0", btb_upd.valid, btb_upd.pc, btb_upd.branch_resol); end
    cyc();
    checks++; if (btb_upd.valid !== 1'b0) begin failures++; $display("FAIL noncf_not_enq got=%b/%h exp=0", btb_upd.valid, btb_upd.pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] pc_next;
    int sent, recv, order_err, first_stall, stall_cycles;
    logic accepted;
    sent = 0; recv = 0; order_err = 0; first_stall = -1; stall_cycles = 0;
    pc_next = 32'h1000;
    for (int c = 0; c < 50; c++) begin
      clear_inputs();
      if (c < 30) begin
        set_lane(0, pc_next, 1'b0, 1'b1, 1'b1, pc_next + 32'h100, 1'b1, pc_next + 32'h100);
        set_lane(1, pc_next + 32'd4, 1'b0, 1'b1, 1'b1, pc_next + 32'h104, 1'b1, pc_next + 32'h104);
      end
      accepted = (c < 30) && !commit_stall;
      if (commit_stall) begin
        stall_cycles++;
        if (first_stall < 0) first_stall = c;
      end
      if (accepted) begin
        exp_q.push_back(pc_next);
        exp_q.push_back(pc_next + 32'd4);
        pc_next = pc_next + 32'd8;
        sent += 2;
      end
      cyc();
      if (btb_upd.valid === 1'b1) begin
        recv++;
        if (exp_q.size() == 0) order_err++;
        else if (btb_upd.pc !== exp_q[0]) order_err++;
        else void'(exp_q.pop_front());
      end
    end
    clear_inputs();
    checks++; if (first_stall != 7) begin failures++; $display("FAIL b2b_first_stall got=%0d exp=7", first_stall); end
    checks++; if (recv != sent) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", recv, sent); end
    checks++; if (order_err != 0) begin failures++; $display("FAIL b2b_order got=%0d errors exp=0", order_err); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
    checks++; if (commit_stall !== 1'b0) begin failures++; $display("FAIL b2b_stall_release got=%b exp=0", commit_stall); end
  endtask

  task automatic test_reset_mid_drain();
    int stale;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      set_lane(0, 32'h2000 + 32'(c * 8), 1'b0, 1'b1, 1'b1, 32'h3000, 1'b1, 32'h3000);
      set_lane(1, 32'h2004 + 32'(c * 8), 1'b1, 1'b0, 1'b1, 32'h3004, 1'b1, 32'h3004);
      cyc();
    end
    clear_inputs();
    checks++; if (btb_upd.valid !== 1'b1) begin failures++; $display("FAIL mid_drain_active got=%b exp=1", btb_upd.valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (btb_upd.valid !== 1'b0 || btb_upd.pc !== 32'h0) begin failures++; $display("FAIL async_reset got=%b/%h exp=0/0", btb_upd.valid, btb_upd.pc); end
    cyc();
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (btb_upd.valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL stale_after_reset got=%0d exp=0", stale); end
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_single_jal();
    test_dual_branch();
    test_mispredict_squash();
    test_redirect_cases();
    test_back_to_back();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
